resp_tx_sequencer: RTL and testbench

Response-side byte sequencer that sits between cmd_parser and async_transmitter inside top_md5, and forms the FPGA-to-host half of the serial command protocol. On a test-command request it streams a countdown pattern ending in 0x01, which the host treats as the terminator. On a match-result request it streams a header byte followed by the match payload, MSB byte first. It paces every byte through the transmitter's start/busy handshake, so the requesting logic never touches the UART directly.

---
 rtl/md5_pkg.sv | 30 +++
 rtl/resp_byte_mux.sv | 19 +
 rtl/resp_tx_sequencer.sv | 141 ++++++++++++++
 tb/tb_resp_tx_sequencer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// Shared definitions for the md5 command/response path: sequencer states,
// response modes, protocol constants and a constant-evaluable clog2.
package md5_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_HOLD    = 3'd2,
    ST_WAIT_TX = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  typedef enum logic {
    MODE_TEST  = 1'b0,
    MODE_MATCH = 1'b1
  } seq_mode_t;

  localparam logic [7:0] MATCH_HDR_DEFAULT = 8'hAA;
  localparam logic [7:0] CMD_TEST          = 8'h04;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/resp_byte_mux.sv
// Combinational payload byte selector; index 0 is the least significant byte.
// Out-of-range indices return zero.
module resp_byte_mux #(
  parameter int NBYTES = 4,
  parameter int IW     = 3
) (
  input  logic [NBYTES*8-1:0] i_data,
  input  logic [IW-1:0]       i_index,
  output logic [7:0]          o_byte
);

  always_comb begin
    o_byte = 8'h00;
    for (int i = 0; i < NBYTES; i++) begin
      if (i_index == IW'(i)) o_byte = i_data[i*8 +: 8];
    end
  end

endmodule

// File: rtl/resp_tx_sequencer.sv
// Response byte sequencer: streams the test countdown or a header+payload
// match response through the transmitter's start/busy handshake.
//
// state    | meaning
// IDLE     | waiting for test_req / match_req
// ISSUE    | waiting for transmitter idle, then strobe current byte
// HOLD     | strobe cycle; busy ignored while the transmitter reacts
// WAIT_TX  | waiting for the byte to finish, then advance count
// DONE     | done pulse, sequencer released
module resp_tx_sequencer
  import md5_pkg::*;
#(
  parameter int         TEST_LEN    = 10,
  parameter int         MATCH_BYTES = 4,
  parameter logic [7:0] MATCH_HDR   = MATCH_HDR_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     test_req,
  input  logic                     match_req,
  input  logic [MATCH_BYTES*8-1:0] match_data,
  input  logic                     txd_busy,
  output logic                     txd_start,
  output logic [7:0]               txd_data,
  output logic                     seq_busy,
  output logic                     done,
  output logic                     req_dropped
);

  localparam int CNT_MAX = (TEST_LEN > MATCH_BYTES + 1) ? TEST_LEN : MATCH_BYTES + 1;
  localparam int CW      = clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] TEST_CNT  = CW'(TEST_LEN);
  localparam logic [CW-1:0] MATCH_CNT = CW'(MATCH_BYTES + 1);

  seq_state_t               r_state;
  seq_mode_t                r_mode;
  logic [CW-1:0]            r_count;
  logic [MATCH_BYTES*8-1:0] r_payload;
  logic                     r_txd_start;
  logic [7:0]               r_txd_data;
  logic                     r_seq_busy;
  logic                     r_done;
  logic                     r_req_dropped;

  logic [CW-1:0] w_mux_idx;
  logic [7:0]    w_mux_byte;
  logic [7:0]    w_cur_byte;

  // Header sits at count MATCH_BYTES+1, so count-1 walks payload MSB-first.
  assign w_mux_idx = r_count - CW'(1);

  resp_byte_mux #(
    .NBYTES (MATCH_BYTES),
    .IW     (CW)
  ) u_byte_mux (
    .i_data  (r_payload),
    .i_index (w_mux_idx),
    .o_byte  (w_mux_byte)
  );

  always_comb begin
    w_cur_byte = 8'h00;
    if (r_mode == MODE_TEST)       w_cur_byte = 8'(r_count);
    else if (r_count == MATCH_CNT) w_cur_byte = MATCH_HDR;
    else                           w_cur_byte = w_mux_byte;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_mode        <= MODE_TEST;
      r_count       <= '0;
      r_payload     <= '0;
      r_txd_start   <= 1'b0;
      r_txd_data    <= 8'h00;
      r_seq_busy    <= 1'b0;
      r_done        <= 1'b0;
      r_req_dropped <= 1'b0;
    end else begin
      r_txd_start   <= 1'b0;
      r_done        <= 1'b0;
      r_req_dropped <= 1'b0;

      if (r_state != ST_IDLE && (test_req || match_req)) r_req_dropped <= 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (match_req) begin
            r_payload     <= match_data;
            r_mode        <= MODE_MATCH;
            r_count       <= MATCH_CNT;
            r_seq_busy    <= 1'b1;
            r_req_dropped <= test_req;
            r_state       <= ST_ISSUE;
          end else if (test_req) begin
            r_mode     <= MODE_TEST;
            r_count    <= TEST_CNT;
            r_seq_busy <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!txd_busy) begin
            r_txd_start <= 1'b1;
            r_txd_data  <= w_cur_byte;
            r_state     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          r_state <= ST_WAIT_TX;
        end
        ST_WAIT_TX: begin
          if (!txd_busy) begin
            r_count <= r_count - CW'(1);
            if (r_count == CW'(1)) begin
              r_done     <= 1'b1;
              r_seq_busy <= 1'b0;
              r_state    <= ST_DONE;
            end else begin
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign txd_start   = r_txd_start;
  assign txd_data    = r_txd_data;
  assign seq_busy    = r_seq_busy;
  assign done        = r_done;
  assign req_dropped = r_req_dropped;

endmodule

// File: tb/tb_resp_tx_sequencer.sv
// Scoreboard bench for resp_tx_sequencer with a stub transmitter whose
// busy time per byte is adjustable.
module tb_resp_tx_sequencer;

  localparam int TEST_LEN = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        test_req;
  logic        match_req;
  logic [31:0] match_data;
  logic        txd_busy;
  logic        txd_start;
  logic [7:0]  txd_data;
  logic        seq_busy;
  logic        done;
  logic        req_dropped;

  always #5 clk = ~clk;

  resp_tx_sequencer #(
    .TEST_LEN    (TEST_LEN),
    .MATCH_BYTES (4),
    .MATCH_HDR   (8'hAA)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .test_req    (test_req),
    .match_req   (match_req),
    .match_data  (match_data),
    .txd_busy    (txd_busy),
    .txd_start   (txd_start),
    .txd_data    (txd_data),
    .seq_busy    (seq_busy),
    .done        (done),
    .req_dropped (req_dropped)
  );

  // Stub transmitter: not reset, so a byte in flight keeps the line busy.
  int busy_len = 5;
  int busy_cnt = 0;
  assign txd_busy = (busy_cnt != 0);
  always @(posedge clk) begin
    if (txd_start === 1'b1 && busy_cnt == 0) busy_cnt <= busy_len;
    else if (busy_cnt != 0)                  busy_cnt <= busy_cnt - 1;
  end

  logic [7:0] sb[$];
  logic [7:0] exp_b;
  int n_pass    = 0;
  int n_total   = 0;
  int n_strobes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && txd_start === 1'b1) begin
      n_strobes++;
      chk("start_while_busy", 32'(txd_busy), 32'd0);
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_byte: got %02h expected none", txd_data);
      end else begin
        exp_b = sb.pop_front();
        chk("tx_byte", 32'(txd_data), 32'(exp_b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_test();
    for (int b = TEST_LEN; b >= 1; b--) sb.push_back(8'(b));
  endtask

  task automatic push_match(input logic [31:0] d);
    sb.push_back(8'hAA);
    sb.push_back(d[31:24]);
    sb.push_back(d[23:16]);
    sb.push_back(d[15:8]);
    sb.push_back(d[7:0]);
  endtask

  task automatic pulse_test();
    test_req = 1'b1;
    tick();
    test_req = 1'b0;
  endtask

  task automatic pulse_match(input logic [31:0] d);
    match_data = d;
    match_req  = 1'b1;
    tick();
    match_req  = 1'b0;
    match_data = 32'h0;
  endtask

  task automatic wait_strobes(input int base, input int n);
    int k;
    k = 0;
    while ((n_strobes - base) < n && k < 3000) begin
      tick();
      k++;
    end
    chk("strobe_wait", 32'(n_strobes - base >= n), 32'd1);
  endtask

  task automatic wait_done(input int base, input int exp_n);
    int k;
    bit seen;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 5000) begin
      tick();
      if (done === 1'b1) seen = 1'b1;
      k++;
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("busy_at_done", 32'(seq_busy), 32'd0);
    chk("byte_count", 32'(n_strobes - base), 32'(exp_n));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    tick();
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  int base;

  initial begin
    reset_n    = 1'b0;
    test_req   = 1'b0;
    match_req  = 1'b0;
    match_data = 32'h0;
    repeat (3) tick();
    chk("rst_start", 32'(txd_start), 32'd0);
    chk("rst_data", 32'(txd_data), 32'd0);
    chk("rst_busy", 32'(seq_busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_drop", 32'(req_dropped), 32'd0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Test pattern 10..1
    base = n_strobes;
    push_test();
    pulse_test();
    chk("busy_after_accept", 32'(seq_busy), 32'd1);
    wait_done(base, TEST_LEN);

    // Match response
    repeat (3) tick();
    base = n_strobes;
    push_match(32'hDEADBEEF);
    pulse_match(32'hDEADBEEF);
    chk("no_drop_single", 32'(req_dropped), 32'd0);
    wait_done(base, 5);

    // Simultaneous requests: match wins
    repeat (3) tick();
    base = n_strobes;
    push_match(32'h11223344);
    match_data = 32'h11223344;
    match_req  = 1'b1;
    test_req   = 1'b1;
    tick();
    match_req  = 1'b0;
    test_req   = 1'b0;
    match_data = 32'h0;
    chk("simul_drop", 32'(req_dropped), 32'd1);
    tick();
    chk("simul_drop_clr", 32'(req_dropped), 32'd0);
    wait_done(base, 5);
    repeat (20) tick();
    chk("no_test_bytes", 32'(n_strobes - base), 32'd5);

    // Request during the 3rd byte of a test sequence
    base = n_strobes;
    push_test();
    pulse_test();
    wait_strobes(base, 3);
    pulse_test();
    chk("busy_drop", 32'(req_dropped), 32'd1);
    tick();
    chk("busy_drop_clr", 32'(req_dropped), 32'd0);
    wait_done(base, TEST_LEN);

    // Reset after the 2nd strobe, then restart
    repeat (3) tick();
    base = n_strobes;
    push_test();
    pulse_test();
    wait_strobes(base, 2);
    reset_n = 1'b0;
    tick();
    chk("mid_rst_outs", {27'd0, txd_start, seq_busy, done, req_dropped, 1'b0}, 32'd0);
    chk("mid_rst_data", 32'(txd_data), 32'd0);
    sb.delete();
    reset_n = 1'b1;
    tick();
    base = n_strobes;
    push_test();
    pulse_test();
    wait_done(base, TEST_LEN);

    // Slow transmitter: 50 busy cycles per byte
    busy_len = 50;
    repeat (3) tick();
    base = n_strobes;
    push_match(32'h01234567);
    pulse_match(32'h01234567);
    wait_done(base, 5);

    repeat (5) tick();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
